wb_port_arbiter: RTL

- Controller for the shared 16-entry architectural register file write side.
- Arbitrates between two writeback requesters for the file's two write ports:
  - requester A: execute-stage writeback (ALU results, IMUL RAX/RDX pair, PUSH/POP RSP updates).
  - requester B: memory-stage load return.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW and saturation hazards.
- Sits between the EX/MEM stage outputs and the register file.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_scoreboard.sv | 49 ++++
 rtl/wb_port_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared constants, writeback request record and port-demand helper
package wb_pkg;
  localparam int NREGS = 16;
  localparam int DW = 64;
  localparam int AW = 4;
  localparam int RSP_IDX = 4;
  localparam int RAX_IDX = 0;
  localparam int RDX_IDX = 2;
  typedef struct packed {
    logic valid;
    logic [1:0] en;
    logic [AW-1:0] dst0;
    logic [AW-1:0] dst1;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
  } wb_req_t;
  function automatic logic [2:0] demand(wb_req_t r);
    return r.valid ? {2'b00, r.en[0]} + {2'b00, r.en[1]} : 3'd0;
  endfunction
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register outstanding-write counters, issue gating and sticky underflow flag
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int CNTW = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             iss_valid,
  input  logic [1:0]       iss_dst_en,
  input  logic [AW-1:0]    iss_dst0,
  input  logic [AW-1:0]    iss_dst1,
  input  logic [NREGS-1:0] iss_src_mask,
  input  logic             wp0_en,
  input  logic [AW-1:0]    wp0_addr,
  input  logic             wp1_en,
  input  logic [AW-1:0]    wp1_addr,
  output logic             iss_ready,
  output logic [NREGS-1:0] sb_busy,
  output logic             sb_err
);
  localparam logic [CNTW-1:0] MAXC = '1;
  logic [CNTW-1:0] cnt [NREGS];
  logic [NREGS-1:0] hit, dec, full, inc;
  always_comb begin
    hit = '0;
    dec = '0;
    full = '0;
    sb_busy = '0;
    for (int i = 0; i < NREGS; i++) begin
      hit[i] = (iss_dst_en[0] && iss_dst0 == AW'(i)) || (iss_dst_en[1] && iss_dst1 == AW'(i));
      dec[i] = (wp0_en && wp0_addr == AW'(i)) || (wp1_en && wp1_addr == AW'(i));
      full[i] = cnt[i] == MAXC;
      sb_busy[i] = cnt[i] != '0;
    end
  end
  assign iss_ready = ~|(iss_src_mask & sb_busy) & ~|(hit & full & ~dec);
  // duplicate destinations collapse into one allocation via the OR in hit
  assign inc = {NREGS{iss_valid & iss_ready}} & hit;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (inc[i] != dec[i]) cnt[i] <= inc[i] ? cnt[i] + 1'b1 : (sb_busy[i] ? cnt[i] - 1'b1 : cnt[i]);
      sb_err <= sb_err | (|(dec & ~inc & ~sb_busy));
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: grants two writeback requesters onto two registered register-file write ports
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int CNTW = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_valid,
  input  logic [1:0]       a_en,
  input  logic [AW-1:0]    a_dst0,
  input  logic [AW-1:0]    a_dst1,
  input  logic [DW-1:0]    a_data0,
  input  logic [DW-1:0]    a_data1,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [1:0]       b_en,
  input  logic [AW-1:0]    b_dst0,
  input  logic [AW-1:0]    b_dst1,
  input  logic [DW-1:0]    b_data0,
  input  logic [DW-1:0]    b_data1,
  output logic             b_ready,
  output logic             wp0_en,
  output logic             wp1_en,
  output logic [AW-1:0]    wp0_addr,
  output logic [AW-1:0]    wp1_addr,
  output logic [DW-1:0]    wp0_data,
  output logic [DW-1:0]    wp1_data,
  input  logic             iss_valid,
  input  logic [1:0]       iss_dst_en,
  input  logic [AW-1:0]    iss_dst0,
  input  logic [AW-1:0]    iss_dst1,
  input  logic [NREGS-1:0] iss_src_mask,
  output logic             iss_ready,
  output logic [NREGS-1:0] sb_busy,
  output logic             sb_err
);
  wb_req_t ra, rb;
  logic rr, ovl, conf, ga, gb;
  logic [3:0] e;
  logic [AW-1:0] sa [4];
  logic [DW-1:0] sd [4];
  logic n0_en, n1_en;
  logic [AW-1:0] n0_addr, n1_addr;
  logic [DW-1:0] n0_data, n1_data;
  assign ra = {a_valid, a_en, a_dst0, a_dst1, a_data0, a_data1};
  assign rb = {b_valid, b_en, b_dst0, b_dst1, b_data0, b_data1};
  assign ovl = (ra.en[0] & rb.en[0] & (ra.dst0 == rb.dst0)) | (ra.en[0] & rb.en[1] & (ra.dst0 == rb.dst1))
             | (ra.en[1] & rb.en[0] & (ra.dst1 == rb.dst0)) | (ra.en[1] & rb.en[1] & (ra.dst1 == rb.dst1));
  assign conf = ra.valid & rb.valid & (ovl | (demand(ra) + demand(rb) > 3'd2));
  // rr=1 hands the next conflict to B
  assign ga = ra.valid & (~conf | ~rr);
  assign gb = rb.valid & (~conf | rr);
  assign a_ready = ga;
  assign b_ready = gb;
  assign e = {gb & rb.en[1], gb & rb.en[0], ga & ra.en[1], ga & ra.en[0]};
  assign sa = '{ra.dst0, ra.dst1, rb.dst0, rb.dst1};
  assign sd = '{ra.data0, ra.data1, rb.data0, rb.data1};
  always_comb begin
    n0_en = 1'b0;
    n1_en = 1'b0;
    n0_addr = '0;
    n1_addr = '0;
    n0_data = '0;
    n1_data = '0;
    for (int i = 0; i < 4; i++)
      if (e[i] && !n0_en) begin
        n0_en = 1'b1;
        n0_addr = sa[i];
        n0_data = sd[i];
      end else if (e[i] && !n1_en) begin
        n1_en = 1'b1;
        n1_addr = sa[i];
        n1_data = sd[i];
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rr <= 1'b0;
      wp0_en <= 1'b0;
      wp1_en <= 1'b0;
      wp0_addr <= '0;
      wp1_addr <= '0;
      wp0_data <= '0;
      wp1_data <= '0;
    end else begin
      rr <= rr ^ conf;
      wp0_en <= n0_en;
      wp1_en <= n1_en;
      wp0_addr <= n0_addr;
      wp1_addr <= n1_addr;
      wp0_data <= n0_data;
      wp1_data <= n1_data;
    end
  wb_scoreboard #(.CNTW(CNTW)) u_sb (
    .clk(clk),
    .reset_n(reset_n),
    .iss_valid(iss_valid),
    .iss_dst_en(iss_dst_en),
    .iss_dst0(iss_dst0),
    .iss_dst1(iss_dst1),
    .iss_src_mask(iss_src_mask),
    .wp0_en(wp0_en),
    .wp0_addr(wp0_addr),
    .wp1_en(wp1_en),
    .wp1_addr(wp1_addr),
    .iss_ready(iss_ready),
    .sb_busy(sb_busy),
    .sb_err(sb_err)
  );
endmodule
